z16_fetch_unit: RTL and testbench
=================================

Name: z16_fetch_unit

Overview:
- Instruction fetch front end for the Z16 core; produces the 16-bit instruction words that the Z16 decoder consumes.
- Holds the PC and issues read requests to instruction memory.
- Buffers returned words in a small prefetch FIFO and presents them to decode over a valid/ready handshake.
- Supports PC redirect (branch/jump) with flush of buffered and in-flight words.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- FIFO_DEPTH, 2, prefetch FIFO entries (power of two, 2..8).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_start  in  1  level; fetching is enabled while high.
- o_imem_req  out  1  read request valid.
- o_imem_addr  out  16  byte address of requested instruction.
- i_imem_gnt  in  1  memory accepts request this cycle.
- i_imem_rvalid  in  1  read data valid; asserted exactly 1 cycle after an accepted request.
- i_imem_rdata  in  16  instruction word.
- i_redirect  in  1  one-cycle pulse; load new PC.
- i_redirect_pc  in  16  target PC; bit 0 is ignored and forced to 0.
- o_instr_valid  out  1  o_instr/o_instr_pc are valid.
- o_instr  out  16  instruction to decoder.
- o_instr_pc  out  16  address of o_instr.
- i_instr_ready  in  1  decoder accepts instruction.
- o_busy  out  1  request in flight or FIFO non-empty.

Behaviour:
- Reset (async, i_rst=1):
  - Outputs: o_imem_req=0, o_imem_addr=RESET_PC, o_instr_valid=0, o_instr=0, o_instr_pc=0, o_busy=0.
  - State: FIFO empty, in-flight count 0, state=IDLE, fetch PC=RESET_PC.
- States:
  - IDLE -> FETCH when i_start=1.
  - FETCH -> IDLE when i_start=0 and no request is in flight.
  - FETCH -> FLUSH on i_redirect while a request is in flight.
  - FLUSH -> FETCH after 1 cycle.
- Request issue:
  - o_imem_req=1 in FETCH when (FIFO count + in-flight) < FIFO_DEPTH (credit rule), and not in the redirect cycle.
  - o_imem_addr = fetch PC (registered).
  - On req&gnt, fetch PC += 2, wrapping 16'hFFFE -> 16'h0000.
  - req may stay high without gnt; the address is held stable until granted.
- Response:
  - i_imem_rvalid writes {rdata, pc_of_request} into the FIFO.
  - The credit rule guarantees the FIFO is never full on rvalid. rvalid while full is a protocol error; the word is dropped and the FIFO must not corrupt.
- Decode handshake:
  - o_instr_valid = FIFO non-empty; o_instr/o_instr_pc = FIFO head (first-word fall-through).
  - Pop on o_instr_valid & i_instr_ready.
  - o_instr and o_instr_pc are held stable while valid=1 and ready=0.
- Latency:
  - Empty FIFO, grant at cycle N -> data at N+1 -> o_instr_valid at N+2 (FIFO output registered).
  - Sustained throughput is 1 instruction/cycle with FIFO_DEPTH>=2 and constant gnt/ready.
- Redirect (highest priority):
  - Same cycle: FIFO flushed, fetch PC <= {i_redirect_pc[15:1],1'b0}, no request issued.
  - A response arriving in the next cycle for a pre-redirect request is discarded (FLUSH state / discard flag).
  - o_instr_valid=0 the cycle after redirect.
  - A pop coinciding with redirect is accepted by the decoder; the flush wins for FIFO state.
- Simultaneous push and pop with count unchanged: legal at any occupancy, including full.
- i_start deasserted mid-stream: no new requests; in-flight data is still captured; FIFO still drains to decode.
- i_rst mid-operation: immediate return to reset values; in-flight responses after reset release are ignored (in-flight count reset to 0, rvalid with count 0 is discarded).
- o_busy = (in-flight != 0) | (FIFO count != 0).

Test Plan:
- Reset then i_start=1, gnt=1, ready=1, memory returns addr^16'hA5A5:
  - addresses 0000,0002,0004... are issued one per cycle.
  - First o_instr_valid occurs 3 cycles after i_start with o_instr=A5A5, o_instr_pc=0000.
  - One instruction per cycle thereafter.
- Backpressure with i_instr_ready=0 held 10 cycles:
  - Exactly FIFO_DEPTH requests (0000,0002) are granted, then o_imem_req=0.
  - o_instr stays A5A5 stable.
  - On ready=1 the stream resumes in order with no loss or duplicate.
- gnt toggles 1,0,0,1:
  - o_imem_addr holds 0002 during the stalled cycles.
  - The PC sequence out of decode is contiguous.
- Redirect to 16'h1235 while 2 entries are buffered and 1 in flight:
  - Buffered and in-flight words never reach decode.
  - Next request address is 1234.
  - Next o_instr_pc is 1234.
- Wrap-around with RESET_PC=FFFC:
  - o_instr_pc sequence is FFFC, FFFE, 0000, 0002.
- Assert i_rst for 1 cycle mid-stream with a request in flight:
  - All outputs return to reset values asynchronously.
  - The stale rvalid is ignored.
  - Restart fetches from RESET_PC.

Source files
------------

// File: rtl/z16_fetch_unit.sv
// Z16 instruction fetch front end: PC/request generation, prefetch FIFO and
// a valid/ready decode port, with redirect flushing buffered and in-flight words.
module z16_fetch_unit #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  output logic        o_imem_req,
  output logic [15:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [15:0] i_imem_rdata,
  input  logic        i_redirect,
  input  logic [15:0] i_redirect_pc,
  output logic        o_instr_valid,
  output logic [15:0] o_instr,
  output logic [15:0] o_instr_pc,
  input  logic        i_instr_ready,
  output logic        o_busy,
  output logic [1:0]  o_dbg_state
);

  // Handshakes: imem request is accepted on o_imem_req & i_imem_gnt and answered
  // by i_imem_rvalid exactly one cycle later; decode consumes on
  // o_instr_valid & i_instr_ready, with o_instr/o_instr_pc stable while waiting.

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW:0]   DEPTH_W = (CW+1)'(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  logic [1:0]    state, state_nxt;
  logic [15:0]   fetch_pc;
  logic [15:0]   req_pc;
  logic [CW-1:0] inflight;
  logic [CW-1:0] fifo_cnt;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [15:0]   instr_mem [FIFO_DEPTH];
  logic [15:0]   pc_mem    [FIFO_DEPTH];

  logic          grant, pop, push, rsp_ok, rsp_retire;
  logic [CW:0]   occupancy;
  logic [15:0]   redirect_target;

  assign redirect_target = i_redirect_pc & 16'hFFFE;
  assign o_instr_valid   = (fifo_cnt != '0);
  assign o_instr         = instr_mem[rd_ptr];
  assign o_instr_pc      = pc_mem[rd_ptr];
  assign o_imem_addr     = fetch_pc;
  assign o_busy          = (inflight != '0) || (fifo_cnt != '0);
  assign o_dbg_state     = state;

  assign pop        = o_instr_valid & i_instr_ready;
  assign grant      = o_imem_req & i_imem_gnt;
  assign rsp_retire = i_imem_rvalid & (inflight != '0);
  // Responses with nothing outstanding (post-reset or post-redirect) are stale.
  assign rsp_ok     = rsp_retire & (state != ST_FLUSH) & ~i_redirect;
  assign push       = rsp_ok & ((fifo_cnt != DEPTH_C) | pop);

  // A slot freed by this cycle's pop can be re-requested at once, which keeps
  // a depth-2 FIFO streaming one word per cycle.
  assign occupancy  = {1'b0, fifo_cnt} + {1'b0, inflight} - (CW+1)'(pop);
  assign o_imem_req = (state == ST_FETCH) & i_start & ~i_redirect & (occupancy < DEPTH_W);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (i_start) state_nxt = ST_FETCH;
      ST_FETCH: begin
        if (i_redirect && inflight != '0)      state_nxt = ST_FLUSH;
        else if (!i_start && inflight == '0)   state_nxt = ST_IDLE;
      end
      ST_FLUSH: state_nxt = ST_FETCH;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= ST_IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
      inflight <= '0;
    end else begin
      state <= state_nxt;
      if (i_redirect)  fetch_pc <= redirect_target;
      else if (grant)  fetch_pc <= fetch_pc + 16'd2;
      if (grant)       req_pc   <= fetch_pc;
      if (i_redirect)  inflight <= '0;
      else             inflight <= inflight + CW'(grant) - CW'(rsp_retire);
    end
  end

  // Flush wins over any simultaneous push or pop.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      fifo_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        instr_mem[i] <= 16'h0000;
        pc_mem[i]    <= 16'h0000;
      end
    end else if (i_redirect) begin
      fifo_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      if (push) begin
        instr_mem[wr_ptr] <= i_imem_rdata;
        pc_mem[wr_ptr]    <= req_pc;
        wr_ptr            <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_z16_fetch_unit.sv
// Directed bench for z16_fetch_unit: instance A (reset PC 0000, depth 2) and
// instance B (reset PC FFFC, depth 4) share clock and reset.
module tb_z16_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;

  logic        start_a, gnt_a, rvalid_a, redirect_a, ready_a;
  logic [15:0] rdata_a, redirect_pc_a;
  logic        req_a, valid_a, busy_a;
  logic [15:0] addr_a, instr_a, ipc_a;
  logic [1:0]  state_a;

  logic        start_b, gnt_b, rvalid_b, redirect_b, ready_b;
  logic [15:0] rdata_b, redirect_pc_b;
  logic        req_b, valid_b, busy_b;
  logic [15:0] addr_b, instr_b, ipc_b;
  logic [1:0]  state_b;

  int          tests  = 0;
  int          failed = 0;
  logic        sb_on  = 1'b0;
  logic        sb_sel = 1'b0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  z16_fetch_unit #(.RESET_PC(16'h0000), .FIFO_DEPTH(2)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_start(start_a),
    .o_imem_req(req_a), .o_imem_addr(addr_a), .i_imem_gnt(gnt_a),
    .i_imem_rvalid(rvalid_a), .i_imem_rdata(rdata_a),
    .i_redirect(redirect_a), .i_redirect_pc(redirect_pc_a),
    .o_instr_valid(valid_a), .o_instr(instr_a), .o_instr_pc(ipc_a),
    .i_instr_ready(ready_a), .o_busy(busy_a), .o_dbg_state(state_a)
  );

  z16_fetch_unit #(.RESET_PC(16'hFFFC), .FIFO_DEPTH(4)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_start(start_b),
    .o_imem_req(req_b), .o_imem_addr(addr_b), .i_imem_gnt(gnt_b),
    .i_imem_rvalid(rvalid_b), .i_imem_rdata(rdata_b),
    .i_redirect(redirect_b), .i_redirect_pc(redirect_pc_b),
    .o_instr_valid(valid_b), .o_instr(instr_b), .o_instr_pc(ipc_b),
    .i_instr_ready(ready_b), .o_busy(busy_b), .o_dbg_state(state_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: sample grants and decode pops before the edge, then answer
  // each granted address one cycle later with addr ^ A5A5.
  task automatic cycle();
    logic        ga, gb, pv;
    logic [15:0] aa, ab, ppc, pin;
    #1;
    ga = req_a & gnt_a;
    aa = addr_a;
    gb = req_b & gnt_b;
    ab = addr_b;
    pv  = sb_sel ? (valid_b & ready_b) : (valid_a & ready_a);
    ppc = sb_sel ? ipc_b : ipc_a;
    pin = sb_sel ? instr_b : instr_a;
    if (sb_on && pv) begin
      check("sb_queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        logic [15:0] e;
        e = exp_q.pop_front();
        check("sb_pc", 32'(ppc), 32'(e));
        check("sb_instr", 32'(pin), 32'(e ^ 16'hA5A5));
      end
    end
    @(posedge clk);
    #1;
    rvalid_a = ga;
    rdata_a  = aa ^ 16'hA5A5;
    rvalid_b = gb;
    rdata_b  = ab ^ 16'hA5A5;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sb_on = 1'b0;
    exp_q.delete();
    start_a = 0; gnt_a = 0; rvalid_a = 0; rdata_a = 0; redirect_a = 0; redirect_pc_a = 0; ready_a = 0;
    start_b = 0; gnt_b = 0; rvalid_b = 0; rdata_b = 0; redirect_b = 0; redirect_pc_b = 0; ready_b = 0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
  endtask

  initial begin
    int ngrant;
    int unstable;

    // Reset values, sampled while reset is held.
    rst = 1'b1;
    start_a = 0; gnt_a = 0; rvalid_a = 0; rdata_a = 0; redirect_a = 0; redirect_pc_a = 0; ready_a = 0;
    start_b = 0; gnt_b = 0; rvalid_b = 0; rdata_b = 0; redirect_b = 0; redirect_pc_b = 0; ready_b = 0;
    #12;
    check("rst_req",   32'(req_a),   32'd0);
    check("rst_addr",  32'(addr_a),  32'h0000);
    check("rst_valid", 32'(valid_a), 32'd0);
    check("rst_instr", 32'(instr_a), 32'h0000);
    check("rst_pc",    32'(ipc_a),   32'h0000);
    check("rst_busy",  32'(busy_a),  32'd0);
    check("rst_state", 32'(state_a), 32'd0);
    check("rst_addr_b", 32'(addr_b), 32'hFFFC);

    // Streaming: first word 3 cycles after start, then one per cycle.
    do_reset();
    start_a = 1; gnt_a = 1; ready_a = 1;
    sb_on = 1; sb_sel = 0;
    exp_q = '{16'h0000, 16'h0002, 16'h0004, 16'h0006, 16'h0008};
    #1;
    check("t1_idle_req", 32'(req_a), 32'd0);
    cycle();
    check("t1_c1_req",   32'(req_a),   32'd1);
    check("t1_c1_addr",  32'(addr_a),  32'h0000);
    check("t1_c1_state", 32'(state_a), 32'd1);
    cycle();
    check("t1_c2_valid", 32'(valid_a), 32'd0);
    check("t1_c2_addr",  32'(addr_a),  32'h0002);
    check("t1_c2_busy",  32'(busy_a),  32'd1);
    cycle();
    check("t1_c3_valid", 32'(valid_a), 32'd1);
    check("t1_c3_instr", 32'(instr_a), 32'hA5A5);
    check("t1_c3_pc",    32'(ipc_a),   32'h0000);
    check("t1_c3_addr",  32'(addr_a),  32'h0004);
    repeat (5) cycle();
    check("t1_drained", 32'(exp_q.size()), 32'd0);

    // Backpressure: ready low for 10 cycles.
    do_reset();
    start_a = 1; gnt_a = 1; ready_a = 0;
    sb_on = 1; sb_sel = 0;
    exp_q = '{16'h0000, 16'h0002, 16'h0004, 16'h0006};
    ngrant = 0;
    unstable = 0;
    for (int i = 0; i < 10; i++) begin
      ngrant += int'(req_a & gnt_a);
      if (valid_a && instr_a !== 16'hA5A5) unstable++;
      cycle();
    end
    check("t2_grants",   32'(ngrant),   32'd2);
    check("t2_req_off",  32'(req_a),    32'd0);
    check("t2_valid",    32'(valid_a),  32'd1);
    check("t2_instr",    32'(instr_a),  32'hA5A5);
    check("t2_pc",       32'(ipc_a),    32'h0000);
    check("t2_stable",   32'(unstable), 32'd0);
    ready_a = 1;
    repeat (4) cycle();
    check("t2_drained", 32'(exp_q.size()), 32'd0);

    // Grant pattern 1,0,0,1: address held while stalled.
    do_reset();
    start_a = 1; gnt_a = 1; ready_a = 1;
    sb_on = 1; sb_sel = 0;
    exp_q = '{16'h0000, 16'h0002, 16'h0004, 16'h0006};
    cycle();
    check("t3_c1_addr", 32'(addr_a), 32'h0000);
    cycle();
    gnt_a = 0;
    check("t3_c2_addr", 32'(addr_a), 32'h0002);
    cycle();
    check("t3_c3_addr", 32'(addr_a), 32'h0002);
    check("t3_c3_req",  32'(req_a),  32'd1);
    cycle();
    gnt_a = 1;
    check("t3_c4_addr", 32'(addr_a), 32'h0002);
    cycle();
    check("t3_c5_addr", 32'(addr_a), 32'h0004);
    repeat (4) cycle();
    check("t3_drained", 32'(exp_q.size()), 32'd0);

    // Wrap-around on instance B.
    do_reset();
    start_b = 1; gnt_b = 1; ready_b = 1;
    sb_on = 1; sb_sel = 1;
    exp_q = '{16'hFFFC, 16'hFFFE, 16'h0000, 16'h0002};
    repeat (3) cycle();
    check("t4_valid", 32'(valid_b), 32'd1);
    check("t4_pc",    32'(ipc_b),   32'hFFFC);
    check("t4_instr", 32'(instr_b), 32'h5A59);
    repeat (4) cycle();
    check("t4_drained", 32'(exp_q.size()), 32'd0);

    // Redirect on B with FFFC/FFFE buffered and 0000 answering this cycle.
    do_reset();
    start_b = 1; gnt_b = 1; ready_b = 0;
    repeat (4) cycle();
    check("t5_pre_valid", 32'(valid_b), 32'd1);
    check("t5_pre_busy",  32'(busy_b),  32'd1);
    check("t5_pre_addr",  32'(addr_b),  32'h0002);
    sb_on = 1; sb_sel = 1;
    exp_q = '{16'h1234, 16'h1236};
    redirect_b = 1; redirect_pc_b = 16'h1235;
    #1;
    check("t5_redir_req", 32'(req_b), 32'd0);
    cycle();
    redirect_b = 0;
    ready_b = 1;
    #1;
    check("t5_flush_valid", 32'(valid_b), 32'd0);
    check("t5_flush_state", 32'(state_b), 32'd2);
    check("t5_flush_addr",  32'(addr_b),  32'h1234);
    check("t5_flush_req",   32'(req_b),   32'd0);
    cycle();
    check("t5_fetch_req",  32'(req_b),  32'd1);
    check("t5_fetch_addr", 32'(addr_b), 32'h1234);
    cycle();
    cycle();
    check("t5_first_valid", 32'(valid_b), 32'd1);
    check("t5_first_pc",    32'(ipc_b),   32'h1234);
    check("t5_first_instr", 32'(instr_b), 32'hB791);
    cycle();
    cycle();
    check("t5_drained", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset mid-stream, then a stale response after release.
    do_reset();
    start_a = 1; gnt_a = 1; ready_a = 1;
    sb_on = 1; sb_sel = 0;
    exp_q = '{16'h0000, 16'h0002};
    repeat (3) cycle();
    check("t6_pre_valid", 32'(valid_a), 32'd1);
    rst = 1'b1;
    #1;
    check("t6_rst_req",   32'(req_a),   32'd0);
    check("t6_rst_addr",  32'(addr_a),  32'h0000);
    check("t6_rst_valid", 32'(valid_a), 32'd0);
    check("t6_rst_instr", 32'(instr_a), 32'h0000);
    check("t6_rst_pc",    32'(ipc_a),   32'h0000);
    check("t6_rst_busy",  32'(busy_a),  32'd0);
    cycle();
    rst = 1'b0;
    rvalid_a = 1'b1;
    rdata_a  = 16'hDEAD;
    #1;
    check("t6_rel_busy", 32'(busy_a), 32'd0);
    cycle();
    check("t6_restart_req",   32'(req_a),   32'd1);
    check("t6_restart_addr",  32'(addr_a),  32'h0000);
    check("t6_stale_dropped", 32'(valid_a), 32'd0);
    repeat (2) cycle();
    check("t6_first_pc",    32'(ipc_a),   32'h0000);
    check("t6_first_instr", 32'(instr_a), 32'hA5A5);
    repeat (2) cycle();
    check("t6_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
